// File: rtl/fetchpc_if.sv
// Instruction-bus request/response and F/D delivery handshake for the fetch stage.
// master = fetch stage, slave = bus + decode side.
interface fetchpc_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        fd_valid;
  logic        fd_ready;
  logic [63:0] fd_pc;
  logic [31:0] fd_instr;
  logic        fd_exc;

  modport master (
    output ireq_valid, ireq_addr, fd_valid, fd_pc, fd_instr, fd_exc,
    input  iresp_data_ok, iresp_data, fd_ready
  );

  modport slave (
    input  ireq_valid, ireq_addr, fd_valid, fd_pc, fd_instr, fd_exc,
    output iresp_data_ok, iresp_data, fd_ready
  );
endinterface

// File: rtl/fetchpc.sv
// Fetch-stage PC register and instruction-bus sequencer with a one-entry
// instruction buffer feeding the F/D register; redirects squash the in-flight fetch.
module fetchpc #(
  parameter logic [63:0] PCINIT = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc_selected,
  input  logic        redirect,
  output logic [63:0] predPC,
  fetchpc_if.master   bus
);
  typedef enum logic [1:0] {FETCH, HOLD, FLUSHWAIT} state_t;

  state_t      state, state_next;
  logic [63:0] pc_q, pc_next;
  logic [63:0] pend_q, pend_next;
  logic [31:0] buf_instr, buf_instr_next;
  logic        buf_exc, buf_exc_next;
  logic        aligned;

  assign aligned = (pc_q[1:0] == 2'b00);
  assign predPC  = pc_q + 64'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      pc_q      <= PCINIT;
      pend_q    <= 64'd0;
      buf_instr <= 32'd0;
      buf_exc   <= 1'b0;
    end else begin
      state     <= state_next;
      pc_q      <= pc_next;
      pend_q    <= pend_next;
      buf_instr <= buf_instr_next;
      buf_exc   <= buf_exc_next;
    end
  end

  always_comb begin
    state_next     = state;
    pc_next        = pc_q;
    pend_next      = pend_q;
    buf_instr_next = buf_instr;
    buf_exc_next   = buf_exc;
    unique case (state)
      FETCH: begin
        if (!aligned) begin
          // No bus access for a misaligned PC; fabricate the faulting slot instead.
          if (redirect) begin
            pc_next = pc_selected;
          end else begin
            buf_instr_next = 32'd0;
            buf_exc_next   = 1'b1;
            state_next     = HOLD;
          end
        end else if (bus.iresp_data_ok) begin
          if (redirect) begin
            pc_next = pc_selected;
          end else begin
            buf_instr_next = bus.iresp_data;
            buf_exc_next   = 1'b0;
            state_next     = HOLD;
          end
        end else if (redirect) begin
          // Request must stay on the bus until answered, so park the target.
          pend_next  = pc_selected;
          state_next = FLUSHWAIT;
        end
      end
      HOLD: begin
        if (redirect || bus.fd_ready) begin
          pc_next    = pc_selected;
          state_next = FETCH;
        end
      end
      FLUSHWAIT: begin
        if (bus.iresp_data_ok) begin
          pc_next    = redirect ? pc_selected : pend_q;
          state_next = FETCH;
        end else if (redirect) begin
          pend_next = pc_selected;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  assign bus.ireq_valid = ~reset & (((state == FETCH) & aligned) | (state == FLUSHWAIT));
  assign bus.ireq_addr  = pc_q;
  assign bus.fd_valid   = (state == HOLD) & ~redirect;
  assign bus.fd_pc      = pc_q;
  assign bus.fd_instr   = buf_instr;
  assign bus.fd_exc     = buf_exc;
endmodule

// File: tb/tb_fetchpc.sv
// Self-checking bench for fetchpc: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_fetchpc;
  localparam logic [63:0] PCINIT = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc_selected;
  logic        redirect;
  logic [63:0] predPC;

  fetchpc_if bus_if ();

  fetchpc #(.PCINIT(PCINIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_selected(pc_selected),
    .redirect   (redirect),
    .predPC     (predPC),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model: current PC, parked redirect target, buffer-full flag, draining flag.
  logic [63:0] m_pc    = PCINIT;
  logic [63:0] m_pend  = 64'd0;
  logic        m_have  = 1'b0;
  logic        m_flush = 1'b0;
  logic [31:0] m_instr = 32'd0;
  logic        m_exc   = 1'b0;
  logic        m_fresh = 1'b0;
  logic        m_init  = 1'b0;

  // Values seen at the sampling point of the most recent cycle.
  logic        cap_req, cap_fdv, cap_exc;
  logic [63:0] cap_addr, cap_fdpc, cap_pred;
  logic [31:0] cap_instr;

  logic        p_valid = 1'b0, p_req = 1'b0, p_dok = 1'b0, p_rst = 1'b0;
  logic [63:0] p_addr  = 64'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic model_req(input logic r);
    return !r && !m_have && (m_flush || (m_pc[1:0] == 2'b00));
  endfunction

  // One clock cycle: drive inputs, sample/check at negedge, advance the model.
  task automatic cycle(input logic r, input logic rd, input logic [63:0] tgt,
                       input logic dok, input logic [31:0] data, input logic rdy);
    logic        e_req, e_fdv;
    logic [63:0] sel;
    sel = rd ? tgt : m_pc + 64'd4;
    reset                = r;
    redirect             = rd;
    pc_selected          = sel;
    bus_if.iresp_data_ok = dok;
    bus_if.iresp_data    = data;
    bus_if.fd_ready      = rdy;
    @(negedge clk);
    cap_req   = bus_if.ireq_valid;
    cap_addr  = bus_if.ireq_addr;
    cap_fdv   = bus_if.fd_valid;
    cap_fdpc  = bus_if.fd_pc;
    cap_instr = bus_if.fd_instr;
    cap_exc   = bus_if.fd_exc;
    cap_pred  = predPC;
    e_req = model_req(r);
    e_fdv = m_have && !rd;
    if (m_init) begin
      chk("ireq_valid", cap_req, e_req);
      chk("predPC", cap_pred, m_pc + 64'd4);
      if (e_req) chk("ireq_addr", cap_addr, m_pc);
      chk("fd_valid", cap_fdv, e_fdv);
      if (e_fdv || m_fresh) begin
        chk("fd_pc", cap_fdpc, m_pc);
        chk("fd_instr", cap_instr, m_instr);
        chk("fd_exc", cap_exc, m_exc);
      end
      if (p_valid && p_req && !p_dok && !p_rst && !r) begin
        chk("bus_hold_valid", cap_req, 1'b1);
        chk("bus_hold_addr", cap_addr, p_addr);
      end
    end
    p_valid = m_init; p_req = cap_req; p_addr = cap_addr; p_dok = dok; p_rst = r;
    if (r) begin
      m_pc = PCINIT; m_pend = 0; m_have = 0; m_flush = 0;
      m_instr = 0; m_exc = 0; m_fresh = 1; m_init = 1;
    end else begin
      m_fresh = 0;
      if (m_have) begin
        if (rd || rdy) begin m_have = 0; m_pc = sel; end
      end else if (m_flush) begin
        if (dok) begin m_flush = 0; m_pc = rd ? sel : m_pend; end
        else if (rd) m_pend = sel;
      end else if (m_pc[1:0] != 2'b00) begin
        if (rd) m_pc = sel;
        else begin m_have = 1; m_instr = 0; m_exc = 1; end
      end else if (dok) begin
        if (rd) m_pc = sel;
        else begin m_have = 1; m_instr = data; m_exc = 0; end
      end else if (rd) begin
        m_flush = 1; m_pend = sel;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic dok, input logic [31:0] data, input logic rdy);
    cycle(1'b0, 1'b0, 64'd0, dok, data, rdy);
  endtask

  task automatic redir(input logic [63:0] tgt, input logic dok, input logic rdy);
    cycle(1'b0, 1'b1, tgt, dok, 32'h0BAD_0BAD, rdy);
  endtask

  initial begin
    logic        r, rd, dok, rdy;
    logic [63:0] tgt;
    logic [31:0] data;

    // Reset and back-to-back fetches with same-cycle responses.
    cycle(1'b1, 1'b0, 64'd0, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 1'b0, 64'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("rst_req", cap_req, 1'b0);
    chk("rst_fdv", cap_fdv, 1'b0);
    chk("rst_fdpc", cap_fdpc, PCINIT);
    chk("rst_instr", cap_instr, 32'd0);
    idle(1'b1, 32'hA000_0000, 1'b0);
    chk("seq_addr0", cap_addr, 64'h8000_0000);
    chk("post_rst_fdpc", cap_fdpc, PCINIT);
    idle(1'b0, 32'd0, 1'b1);
    chk("seq_fdv0", cap_fdv, 1'b1);
    chk("seq_instr0", cap_instr, 32'hA000_0000);
    idle(1'b1, 32'hA000_0001, 1'b0);
    chk("seq_addr1", cap_addr, 64'h8000_0004);
    idle(1'b0, 32'd0, 1'b1);
    chk("seq_fdpc1", cap_fdpc, 64'h8000_0004);
    idle(1'b1, 32'hA000_0002, 1'b0);
    chk("seq_addr2", cap_addr, 64'h8000_0008);
    idle(1'b0, 32'd0, 1'b1);

    // Latency 3 then decode stalls for 4 cycles.
    repeat (3) begin
      idle(1'b0, 32'd0, 1'b0);
      chk("slow_addr", cap_addr, 64'h8000_000C);
    end
    idle(1'b1, 32'hA000_0003, 1'b0);
    repeat (4) begin
      idle(1'b0, 32'd0, 1'b0);
      chk("stall_fdpc", cap_fdpc, 64'h8000_000C);
      chk("stall_instr", cap_instr, 32'hA000_0003);
    end
    idle(1'b0, 32'd0, 1'b1);

    // Redirect while a request is outstanding, re-redirect during the drain.
    idle(1'b0, 32'd0, 1'b0);
    redir(64'h8000_0100, 1'b0, 1'b0);
    idle(1'b0, 32'd0, 1'b0);
    chk("flush_addr", cap_addr, 64'h8000_0010);
    redir(64'h8000_0200, 1'b0, 1'b0);
    idle(1'b1, 32'hA000_0004, 1'b0);
    chk("flush_addr2", cap_addr, 64'h8000_0010);
    idle(1'b1, 32'hA000_0005, 1'b0);
    chk("after_flush_addr", cap_addr, 64'h8000_0200);
    idle(1'b0, 32'd0, 1'b1);
    chk("after_flush_instr", cap_instr, 32'hA000_0005);

    // Redirect in HOLD beats fd_ready.
    idle(1'b1, 32'hA000_0006, 1'b0);
    redir(64'h8000_0040, 1'b0, 1'b1);
    chk("hold_redir_fdv", cap_fdv, 1'b0);
    idle(1'b1, 32'hA000_0007, 1'b0);
    chk("hold_redir_addr", cap_addr, 64'h8000_0040);
    idle(1'b0, 32'd0, 1'b1);

    // Misaligned target.
    idle(1'b1, 32'hA000_0008, 1'b0);
    redir(64'h8000_0042, 1'b0, 1'b0);
    idle(1'b0, 32'd0, 1'b0);
    chk("mis_req", cap_req, 1'b0);
    idle(1'b0, 32'd0, 1'b0);
    chk("mis_fdv", cap_fdv, 1'b1);
    chk("mis_exc", cap_exc, 1'b1);
    chk("mis_instr", cap_instr, 32'd0);
    chk("mis_fdpc", cap_fdpc, 64'h8000_0042);
    redir(64'h8000_0080, 1'b0, 1'b1);

    // Reset while draining a squashed request.
    idle(1'b0, 32'd0, 1'b0);
    redir(64'h8000_0300, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 64'd0, 1'b1, 32'hDEAD_DEAD, 1'b0);
    chk("rst_flush_req", cap_req, 1'b0);
    idle(1'b0, 32'd0, 1'b0);
    chk("rst_flush_req2", cap_req, 1'b1);
    chk("rst_flush_addr", cap_addr, PCINIT);
    chk("rst_flush_fdv", cap_fdv, 1'b0);

    // PC wraparound at the top of the address space.
    redir(64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0);
    idle(1'b0, 32'd0, 1'b0);
    chk("wrap_addr", cap_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_pred", cap_pred, 64'd0);
    idle(1'b1, 32'hA000_0009, 1'b0);
    idle(1'b0, 32'd0, 1'b1);
    idle(1'b0, 32'd0, 1'b0);
    chk("wrap_next_addr", cap_addr, 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r    = ($urandom_range(0, 199) == 0);
      rd   = ($urandom_range(0, 7) == 0);
      dok  = model_req(r) ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (r && $urandom_range(0, 1) == 1) dok = 1'b1;
      rdy  = $urandom_range(0, 1) == 1;
      data = $urandom;
      case ($urandom_range(0, 7))
        0:       tgt = 64'hFFFF_FFFF_FFFF_FFF0 + {60'd0, 2'($urandom_range(0, 3)), 2'b00};
        1:       tgt = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 4 + 64'($urandom_range(1, 3));
        default: tgt = 64'h8000_0000 + 64'($urandom_range(0, 1023)) * 4;
      endcase
      cycle(r, rd, tgt, dok, data, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
